// File: rtl/irq_vector_ctrl_if.sv
// ---------------------------------------------------------------------------
// irq_vector_ctrl_if : core <-> interrupt controller signal bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface irq_vector_ctrl_if #(
  parameter int NUM_IRQ = 8,
  parameter int ADDR_W  = 32
);
  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [NUM_IRQ-1:0] irq;
  logic               nmi;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               boundary;
  logic               busy;
  logic               eret;
  logic [ADDR_W-1:0]  pc_in;
  logic               take_int;
  logic [ADDR_W-1:0]  int_vector;
  logic               ret_valid;
  logic [ADDR_W-1:0]  ret_pc;
  logic [ID_W-1:0]    cause;
  logic               in_service;
  logic               nmi_active;
  logic [NUM_IRQ-1:0] mask_out;

  modport master (
    output irq, nmi, mask_we, mask_wdata, boundary, busy, eret, pc_in,
    input  take_int, int_vector, ret_valid, ret_pc, cause, in_service,
           nmi_active, mask_out
  );

  modport slave (
    input  irq, nmi, mask_we, mask_wdata, boundary, busy, eret, pc_in,
    output take_int, int_vector, ret_valid, ret_pc, cause, in_service,
           nmi_active, mask_out
  );
endinterface

`default_nettype wire

// File: rtl/irq_vector_ctrl.sv
// ---------------------------------------------------------------------------
// irq_vector_ctrl : fixed-priority vectored interrupt controller with
//                   edge-latched preempting NMI and two exception-PC slots
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module irq_vector_ctrl #(
  parameter int NUM_IRQ       = 8,
  parameter int ADDR_W        = 32,
  parameter int VECTOR_BASE   = 32,
  parameter int VECTOR_STRIDE = 8,
  parameter int NMI_VECTOR    = 20
) (
  input  logic             clk,
  input  logic             reset,
  irq_vector_ctrl_if.slave bus
);

  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_IRQ_SVC      = 2'd1;
  localparam logic [1:0] S_NMI_SVC      = 2'd2;
  localparam logic [1:0] S_NMI_OVER_IRQ = 2'd3;

  logic [1:0]         r_state;
  logic               r_nmi_q;
  logic               r_nmi_pend;
  logic [NUM_IRQ-1:0] r_mask;
  logic [ADDR_W-1:0]  r_epc;
  logic [ADDR_W-1:0]  r_nmi_epc;
  logic [ID_W-1:0]    r_cause;
  logic               r_take;
  logic [ADDR_W-1:0]  r_vector;
  logic               r_ret_valid;
  logic [ADDR_W-1:0]  r_ret_pc;

  logic [NUM_IRQ-1:0] w_req;
  logic [ID_W-1:0]    w_winner;
  logic               w_nmi_edge;
  logic               w_can_take;
  logic               w_take_nmi;
  logic               w_take_irq;
  logic [ADDR_W-1:0]  w_irq_vector;

  assign w_req      = bus.irq & r_mask;
  assign w_nmi_edge = bus.nmi & ~r_nmi_q;
  assign w_can_take = bus.boundary & ~bus.busy & ~bus.eret;

  // NMI may preempt only from IDLE or a maskable handler, never itself.
  assign w_take_nmi = w_can_take & r_nmi_pend &
                      ((r_state == S_IDLE) | (r_state == S_IRQ_SVC));
  assign w_take_irq = w_can_take & ~r_nmi_pend & (r_state == S_IDLE) & (|w_req);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    w_winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_winner = ID_W'(i);
      end
    end
  end

  assign w_irq_vector = ADDR_W'(VECTOR_BASE) +
                        ADDR_W'(w_winner) * ADDR_W'(VECTOR_STRIDE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_nmi_q     <= 1'b0;
      r_nmi_pend  <= 1'b0;
      r_mask      <= '0;
      r_epc       <= '0;
      r_nmi_epc   <= '0;
      r_cause     <= '0;
      r_take      <= 1'b0;
      r_vector    <= '0;
      r_ret_valid <= 1'b0;
      r_ret_pc    <= '0;
    end else begin
      r_take      <= 1'b0;
      r_ret_valid <= 1'b0;
      r_nmi_q     <= bus.nmi;

      if (bus.mask_we) begin
        r_mask <= bus.mask_wdata;
      end

      // A fresh edge coinciding with the take re-arms the latch.
      if (w_take_nmi) begin
        r_nmi_pend <= w_nmi_edge;
      end else if (w_nmi_edge) begin
        r_nmi_pend <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_take_nmi) begin
            r_state   <= S_NMI_SVC;
            r_nmi_epc <= bus.pc_in;
            r_vector  <= ADDR_W'(NMI_VECTOR);
            r_take    <= 1'b1;
          end else if (w_take_irq) begin
            r_state  <= S_IRQ_SVC;
            r_epc    <= bus.pc_in;
            r_cause  <= w_winner;
            r_vector <= w_irq_vector;
            r_take   <= 1'b1;
          end
        end
        S_IRQ_SVC: begin
          if (bus.eret) begin
            r_state     <= S_IDLE;
            r_ret_pc    <= r_epc;
            r_ret_valid <= 1'b1;
            r_cause     <= '0;
          end else if (w_take_nmi) begin
            r_state   <= S_NMI_OVER_IRQ;
            r_nmi_epc <= bus.pc_in;
            r_vector  <= ADDR_W'(NMI_VECTOR);
            r_take    <= 1'b1;
          end
        end
        S_NMI_SVC: begin
          if (bus.eret) begin
            r_state     <= S_IDLE;
            r_ret_pc    <= r_nmi_epc;
            r_ret_valid <= 1'b1;
          end
        end
        S_NMI_OVER_IRQ: begin
          if (bus.eret) begin
            r_state     <= S_IRQ_SVC;
            r_ret_pc    <= r_nmi_epc;
            r_ret_valid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.take_int   = r_take;
  assign bus.int_vector = r_vector;
  assign bus.ret_valid  = r_ret_valid;
  assign bus.ret_pc     = r_ret_pc;
  assign bus.cause      = r_cause;
  assign bus.in_service = (r_state == S_IRQ_SVC) | (r_state == S_NMI_OVER_IRQ);
  assign bus.nmi_active = (r_state == S_NMI_SVC) | (r_state == S_NMI_OVER_IRQ);
  assign bus.mask_out   = r_mask;

endmodule

`default_nettype wire

// File: tb/tb_irq_vector_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_vector_ctrl : scoreboard bench for irq_vector_ctrl with a
//                      handler-stack reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_irq_vector_ctrl;

  localparam int NUM_IRQ = 8;
  localparam int ADDR_W  = 32;
  localparam int VB      = 32;
  localparam int VS      = 8;
  localparam int NV      = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  irq_vector_ctrl_if #(.NUM_IRQ(NUM_IRQ), .ADDR_W(ADDR_W)) bus ();

  irq_vector_ctrl #(
    .NUM_IRQ(NUM_IRQ), .ADDR_W(ADDR_W), .VECTOR_BASE(VB),
    .VECTOR_STRIDE(VS), .NMI_VECTOR(NV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    bit          is_ret;
    logic [31:0] val;
  } ev_t;

  ev_t         sb[$];
  // Reference model: a stack of active handlers, each with its return PC.
  logic [31:0] stk_pc[$];
  bit          stk_nmi[$];
  logic [7:0]  m_mask;
  bit          m_prev, m_pend;
  int          m_cause;
  bit          exp_in_service, exp_nmi_active;

  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  bit  mdl_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    stk_pc.delete();
    stk_nmi.delete();
    sb.delete();
    m_mask = '0; m_prev = 0; m_pend = 0; m_cause = 0;
    exp_in_service = 0; exp_nmi_active = 0;
  endtask

  task automatic model_step();
    bit         can, took_nmi;
    logic [7:0] req, lowbit;
    int         w;
    ev_t        e;
    can = bus.boundary && !bus.busy && !bus.eret;
    took_nmi = 0;
    req = bus.irq & m_mask;
    if (bus.eret && stk_pc.size() > 0) begin
      e.is_ret = 1; e.val = stk_pc[$];
      sb.push_back(e);
      if (!stk_nmi[$]) m_cause = 0;
      void'(stk_pc.pop_back());
      void'(stk_nmi.pop_back());
    end else if (can && m_pend && (stk_pc.size() == 0 || !stk_nmi[$])) begin
      stk_pc.push_back(bus.pc_in); stk_nmi.push_back(1);
      took_nmi = 1;
      e.is_ret = 0; e.val = NV;
      sb.push_back(e);
    end else if (can && stk_pc.size() == 0 && req != 0) begin
      lowbit = req & (~req + 8'd1);
      w = $clog2(lowbit);
      stk_pc.push_back(bus.pc_in); stk_nmi.push_back(0);
      m_cause = w;
      e.is_ret = 0; e.val = VB + w * VS;
      sb.push_back(e);
    end
    m_pend = (took_nmi ? 1'b0 : m_pend) | (bus.nmi && !m_prev);
    m_prev = bus.nmi;
    if (bus.mask_we) m_mask = bus.mask_wdata;
    exp_in_service = 0; exp_nmi_active = 0;
    foreach (stk_nmi[i]) begin
      if (stk_nmi[i]) exp_nmi_active = 1;
      else            exp_in_service = 1;
    end
  endtask

  // Model advances once per cycle using the inputs driven at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mdl_en) model_step();
    end
  end

  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("in_service", bus.in_service, exp_in_service);
        chk("nmi_active", bus.nmi_active, exp_nmi_active);
        chk("cause", bus.cause, m_cause);
        chk("mask_out", bus.mask_out, m_mask);
        chk("take_ret_excl", bus.take_int & bus.ret_valid, 0);
        if (bus.take_int || bus.ret_valid) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event take=%0b ret=%0b required=none at %0t",
                     bus.take_int, bus.ret_valid, $time);
          end else begin
            e = sb.pop_front();
            chk("event_kind", bus.ret_valid, e.is_ret);
            chk("event_val", bus.ret_valid ? bus.ret_pc : bus.int_vector, e.val);
          end
        end
        chk("missing_event", sb.size(), 0);
      end
    end
  end

  task automatic drive(input logic [7:0] irq_v, input logic nmi_v, input logic we,
                       input logic [7:0] wd, input logic bnd, input logic bsy,
                       input logic er, input logic [31:0] pc);
    @(negedge clk);
    bus.irq = irq_v; bus.nmi = nmi_v; bus.mask_we = we; bus.mask_wdata = wd;
    bus.boundary = bnd; bus.busy = bsy; bus.eret = er; bus.pc_in = pc;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    bus.irq = '0; bus.nmi = 0; bus.mask_we = 0; bus.mask_wdata = '0;
    bus.boundary = 0; bus.busy = 0; bus.eret = 0; bus.pc_in = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_take", bus.take_int, 0);
    chk("rst_vector", bus.int_vector, 0);
    chk("rst_mask", bus.mask_out, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    mdl_en = 1; mon_en = 1;

    // Winner among irq[3] and irq[5] is channel 3.
    drive(8'h00, 0, 1, 8'hFF, 0, 0, 0, 0);
    drive(8'h28, 0, 0, 8'h00, 1, 0, 0, 32'h100);
    after_edge();
    chk("t1_take", bus.take_int, 1);
    chk("t1_vector", bus.int_vector, 56);
    chk("t1_cause", bus.cause, 3);
    chk("t1_in_service", bus.in_service, 1);
    drive(8'h00, 0, 0, 8'h00, 0, 0, 1, 0);
    after_edge();
    chk("t1_ret_valid", bus.ret_valid, 1);
    chk("t1_ret_pc", bus.ret_pc, 32'h100);
    chk("t1_idle", bus.in_service, 0);

    // Masked requests are ignored; same-cycle mask write uses the old mask.
    drive(8'h00, 0, 1, 8'hF0, 0, 0, 0, 0);
    drive(8'h0F, 0, 0, 8'h00, 1, 0, 0, 32'h300);
    after_edge();
    chk("t2_masked", bus.take_int, 0);
    drive(8'h0F, 0, 1, 8'h02, 1, 0, 0, 32'h300);
    after_edge();
    chk("t2_old_mask", bus.take_int, 0);
    drive(8'h0F, 0, 0, 8'h00, 1, 0, 0, 32'h100);
    after_edge();
    chk("t2_take", bus.take_int, 1);
    chk("t2_vector", bus.int_vector, 40);
    chk("t2_cause", bus.cause, 1);

    // NMI preempts the channel-1 handler, then two returns unwind.
    drive(8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
    drive(8'h00, 1, 0, 8'h00, 1, 0, 0, 32'h200);
    after_edge();
    chk("t3_take", bus.take_int, 1);
    chk("t3_vector", bus.int_vector, NV);
    chk("t3_nmi_active", bus.nmi_active, 1);
    chk("t3_in_service", bus.in_service, 1);
    drive(8'h00, 1, 0, 8'h00, 0, 0, 1, 0);
    after_edge();
    chk("t3_ret1_pc", bus.ret_pc, 32'h200);
    chk("t3_ret1_cause", bus.cause, 1);
    chk("t3_ret1_nmi", bus.nmi_active, 0);
    drive(8'h00, 0, 0, 8'h00, 0, 0, 1, 0);
    after_edge();
    chk("t3_ret2_pc", bus.ret_pc, 32'h100);
    chk("t3_ret2_svc", bus.in_service, 0);

    // NMI and irq[0] together while busy: NMI first, irq only after its return.
    drive(8'h00, 0, 1, 8'hFF, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(8'h01, 1, 0, 8'h00, 1, 1, 0, 32'h400);
      after_edge();
      chk("t4_busy", bus.take_int, 0);
    end
    drive(8'h01, 1, 0, 8'h00, 1, 0, 0, 32'h400);
    after_edge();
    chk("t4_nmi_vec", bus.int_vector, NV);
    chk("t4_nmi_svc", bus.in_service, 0);
    drive(8'h01, 1, 0, 8'h00, 1, 0, 0, 32'h404);
    after_edge();
    chk("t4_no_nest", bus.take_int, 0);
    drive(8'h01, 1, 0, 8'h00, 1, 0, 1, 0);
    after_edge();
    chk("t4_ret", bus.ret_valid, 1);
    chk("t4_ret_no_take", bus.take_int, 0);
    drive(8'h01, 0, 0, 8'h00, 1, 0, 0, 32'h408);
    after_edge();
    chk("t4_irq0_vec", bus.int_vector, 32);

    // eret with a pending request at a boundary: return first, take next cycle.
    drive(8'h01, 0, 0, 8'h00, 1, 0, 1, 0);
    after_edge();
    chk("t5_ret", bus.ret_valid, 1);
    chk("t5_no_take", bus.take_int, 0);
    drive(8'h01, 0, 0, 8'h00, 1, 0, 0, 32'h500);
    after_edge();
    chk("t5_take", bus.take_int, 1);
    drive(8'h00, 0, 0, 8'h00, 0, 0, 1, 0);
    after_edge();
    chk("t5_ret_pc", bus.ret_pc, 32'h500);
    drive(8'h00, 0, 0, 8'h00, 0, 0, 1, 0);
    after_edge();
    chk("t5_idle_eret", bus.ret_valid, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(8'($urandom & $urandom),
            ($urandom_range(0, 7) == 0) ? ~bus.nmi : bus.nmi,
            ($urandom_range(0, 19) == 0),
            8'($urandom),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0,
            $urandom & 32'hFFFF_FFFC);
    end
    repeat (3) drive(8'h00, 0, 0, 8'h00, 0, 0, 1, 0);

    // Reach NMI_OVER_IRQ with another NMI pending, then reset between edges.
    drive(8'h00, 0, 1, 8'hFF, 0, 0, 0, 0);
    drive(8'h02, 0, 0, 8'h00, 1, 0, 0, 32'h600);
    drive(8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
    drive(8'h00, 1, 0, 8'h00, 1, 0, 0, 32'h700);
    drive(8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
    drive(8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
    after_edge();
    chk("t6_pre_nmi", bus.nmi_active, 1);
    chk("t6_pre_svc", bus.in_service, 1);
    #1;
    mon_en = 0; mdl_en = 0;
    reset = 1'b1;
    #1;
    chk("t6_take", bus.take_int, 0);
    chk("t6_vector", bus.int_vector, 0);
    chk("t6_ret_valid", bus.ret_valid, 0);
    chk("t6_ret_pc", bus.ret_pc, 0);
    chk("t6_cause", bus.cause, 0);
    chk("t6_in_service", bus.in_service, 0);
    chk("t6_nmi_active", bus.nmi_active, 0);
    chk("t6_mask", bus.mask_out, 0);
    @(negedge clk);
    bus.irq = 8'hFF; bus.nmi = 0; bus.mask_we = 0; bus.boundary = 1;
    bus.busy = 0; bus.eret = 0; bus.pc_in = 32'h800;
    reset = 1'b0;
    model_reset();
    mdl_en = 1; mon_en = 1;
    for (int i = 0; i < 4; i++) begin
      after_edge();
      chk("t6_no_take", bus.take_int, 0);
    end

    drive(8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
    after_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
